// File: rtl/regfile_pkg.sv
// Shared defaults and types for the regfile_sb register file and its busy scoreboard.
package regfile_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam int unsigned NREG_DEF     = 32;
   localparam int unsigned ZERO_REG_DEF = 1;
   localparam int unsigned AW_DEF       = $clog2(NREG_DEF);

   typedef logic [AW_DEF-1:0] reg_addr_t;

   // Per-cycle change applied to the busy popcount
   typedef enum logic [1:0] {
      HOLD = 2'd0,
      INC  = 2'd1,
      DEC  = 2'd2
   } cnt_delta_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector with a registered popcount; issue (set) wins over clear
// when both target the same register in one cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREG     = NREG_DEF,
   parameter int unsigned AW       = $clog2(NREG),
   parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_valid_i,
   input  logic [AW-1:0] set_addr_i,
   input  logic          clr_valid_i,
   input  logic [AW-1:0] clr_addr_i,
   input  logic [AW-1:0] lk1_addr_i,
   input  logic [AW-1:0] lk2_addr_i,
   output logic          busy1_o,
   output logic          busy2_o,
   output logic [AW:0]   busy_cnt_o
);

   localparam int unsigned CW = AW + 1;
   localparam bit          ZR = (ZERO_REG != 0);

   logic [NREG-1:0] busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            set_eff, clr_eff, inc, dec;
   cnt_delta_e      delta;

   assign set_eff = set_valid_i && !(ZR && (set_addr_i == '0));
   assign clr_eff = clr_valid_i && !(ZR && (clr_addr_i == '0));

   // Next busy vector and the popcount delta it implies
   always_comb begin
      busy_d = busy_q;
      inc    = 1'b0;
      dec    = 1'b0;
      delta  = HOLD;
      cnt_d  = cnt_q;
      if (clr_eff) busy_d[clr_addr_i] = 1'b0;
      if (set_eff) busy_d[set_addr_i] = 1'b1;
      inc = set_eff && !busy_q[set_addr_i];
      dec = clr_eff && busy_q[clr_addr_i] && !(set_eff && (set_addr_i == clr_addr_i));
      if (inc && !dec)      delta = INC;
      else if (dec && !inc) delta = DEC;
      case (delta)
         INC:     cnt_d = cnt_q + CW'(1);
         DEC:     cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy1_o    = busy_q[lk1_addr_i];
   assign busy2_o    = busy_q[lk2_addr_i];
   assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// MIPS GPR file with two combinational read ports, one write port and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREG     = NREG_DEF,
   parameter int unsigned AW       = $clog2(NREG),
   parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_dst,
   output logic            busy1,
   output logic            busy2,
   output logic [AW:0]     busy_cnt
);

   localparam bit ZR = (ZERO_REG != 0);

   logic [XLEN-1:0] regs_q [NREG];
   logic            wr_eff;
   logic            sb_busy1, sb_busy2;
   logic [XLEN-1:0] st_rd1, st_rd2;

   // Writes coincident with reset are dropped, as are writes to a hardwired zero register
   assign wr_eff = we && !rst && !(ZR && (wa == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else if (wr_eff) begin
         regs_q[wa] <= wd;
      end
   end

   regfile_scoreboard #(
      .NREG     (NREG),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .set_valid_i (iss_valid),
      .set_addr_i  (iss_dst),
      .clr_valid_i (wr_eff),
      .clr_addr_i  (wa),
      .lk1_addr_i  (ra1),
      .lk2_addr_i  (ra2),
      .busy1_o     (sb_busy1),
      .busy2_o     (sb_busy2),
      .busy_cnt_o  (busy_cnt)
   );

   assign st_rd1 = (ZR && (ra1 == '0)) ? '0 : regs_q[ra1];
   assign st_rd2 = (ZR && (ra2 == '0)) ? '0 : regs_q[ra2];

`ifdef REGFILE_BYPASS_EN
   logic hit1, hit2;
   assign hit1 = wr_eff && (wa == ra1);
   assign hit2 = wr_eff && (wa == ra2);

   // Forwarded data is final this cycle, so the reader sees it as not busy
   always_comb begin
      rd1   = hit1 ? wd : st_rd1;
      rd2   = hit2 ? wd : st_rd2;
      busy1 = sb_busy1 && !hit1;
      busy2 = sb_busy2 && !hit2;
   end
`else
   always_comb begin
      rd1   = st_rd1;
      rd2   = st_rd2;
      busy1 = sb_busy1;
      busy2 = sb_busy2;
   end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            we;
   logic [AW-1:0]   wa;
   logic [XLEN-1:0] wd;
   logic [AW-1:0]   ra1, ra2;
   logic [XLEN-1:0] rd1, rd2;
   logic            iss_valid;
   logic [AW-1:0]   iss_dst;
   logic            busy1, busy2;
   logic [AW:0]     busy_cnt;

   int checks = 0;
   int errors = 0;

   regfile_sb dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .wa        (wa),
      .wd        (wd),
      .ra1       (ra1),
      .ra2       (ra2),
      .rd1       (rd1),
      .rd2       (rd2),
      .iss_valid (iss_valid),
      .iss_dst   (iss_dst),
      .busy1     (busy1),
      .busy2     (busy2),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; iss_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
      iss_valid = 1'b0; iss_dst = '0;
      #3;
      check("rst_rd1", rd1, 32'h0);
      check("rst_busy1", 32'(busy1), 32'h0);
      check("rst_cnt", 32'(busy_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // write then read r8
      we = 1'b1; wa = 5'd8; wd = 32'h4; ra2 = 5'd8;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("wr_same_cycle_rd2", rd2, 32'h4);
`else
      check("wr_same_cycle_rd2", rd2, 32'h0);
`endif
      tick(); idle();
      check("wr_next_rd2", rd2, 32'h4);

      // zero register ignores write and issue
      we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_dst = 5'd0; ra1 = 5'd0;
      tick(); idle();
      check("zero_rd1", rd1, 32'h0);
      check("zero_busy1", 32'(busy1), 32'h0);
      check("zero_cnt", 32'(busy_cnt), 32'h0);

      // issue r5, then write it back
      iss_valid = 1'b1; iss_dst = 5'd5; ra1 = 5'd5;
      tick(); idle();
      check("iss5_busy1", 32'(busy1), 32'h1);
      check("iss5_cnt", 32'(busy_cnt), 32'h1);
      we = 1'b1; wa = 5'd5; wd = 32'h1234;
      tick(); idle();
      check("wb5_busy1", 32'(busy1), 32'h0);
      check("wb5_rd1", rd1, 32'h1234);
      check("wb5_cnt", 32'(busy_cnt), 32'h0);

      // r7 busy, then issue+write r7 together: issue wins
      iss_valid = 1'b1; iss_dst = 5'd7;
      tick(); idle();
      check("iss7_cnt", 32'(busy_cnt), 32'h1);
      iss_valid = 1'b1; iss_dst = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h9; ra1 = 5'd7;
      tick(); idle();
      check("r7_rd1", rd1, 32'h9);
      check("r7_busy1", 32'(busy1), 32'h1);
      check("r7_cnt", 32'(busy_cnt), 32'h1);

      // r6 busy, then issue r2 while writing r6
      iss_valid = 1'b1; iss_dst = 5'd6;
      tick(); idle();
      check("iss6_cnt", 32'(busy_cnt), 32'h2);
      iss_valid = 1'b1; iss_dst = 5'd2; we = 1'b1; wa = 5'd6; wd = 32'h66; ra1 = 5'd6; ra2 = 5'd2;
      tick(); idle();
      check("swap_cnt", 32'(busy_cnt), 32'h2);
      check("swap_busy_r6", 32'(busy1), 32'h0);
      check("swap_busy_r2", 32'(busy2), 32'h1);

      // re-issue an already-busy register
      iss_valid = 1'b1; iss_dst = 5'd2;
      tick(); idle();
      check("reiss_cnt", 32'(busy_cnt), 32'h2);

      // write to a non-busy register
      we = 1'b1; wa = 5'd9; wd = 32'h55; ra1 = 5'd9;
      tick(); idle();
      check("nb_rd1", rd1, 32'h55);
      check("nb_busy1", 32'(busy1), 32'h0);
      check("nb_cnt", 32'(busy_cnt), 32'h2);

      // issue and write together to a non-busy register
      iss_valid = 1'b1; iss_dst = 5'd10; we = 1'b1; wa = 5'd10; wd = 32'hA0; ra2 = 5'd10;
      tick(); idle();
      check("r10_rd2", rd2, 32'hA0);
      check("r10_busy2", 32'(busy2), 32'h1);
      check("r10_cnt", 32'(busy_cnt), 32'h3);

      // bypass behaviour on r4 with coincident issue
      we = 1'b1; wa = 5'd4; wd = 32'hABCD; ra1 = 5'd4; iss_valid = 1'b1; iss_dst = 5'd4;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_rd1", rd1, 32'hABCD);
      check("byp_busy1", 32'(busy1), 32'h0);
`else
      check("byp_rd1", rd1, 32'h0);
      check("byp_busy1", 32'(busy1), 32'h0);
`endif
      tick(); idle();
      check("r4_rd1", rd1, 32'hABCD);
      check("r4_busy1", 32'(busy1), 32'h1);
      check("r4_cnt", 32'(busy_cnt), 32'h4);

      // asynchronous reset mid-cycle clears everything
      we = 1'b1; wa = 5'd3; wd = 32'h5; ra1 = 5'd3; ra2 = 5'd2;
      tick(); idle();
      check("r3_pre_rst", rd1, 32'h5);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_rd1", rd1, 32'h0);
      check("rst_async_cnt", 32'(busy_cnt), 32'h0);
      check("rst_async_busy2", 32'(busy2), 32'h0);
      we = 1'b1; wa = 5'd3; wd = 32'h7; iss_valid = 1'b1; iss_dst = 5'd3;
      tick(); idle();
      check("rst_wr_dropped", rd1, 32'h0);
      check("rst_iss_dropped", 32'(busy1), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("post_rst_rd1", rd1, 32'h0);
      check("post_rst_cnt", 32'(busy_cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
